// File: rtl/hps_ext_pkg.sv
// Shared constants for the HPS extension-bus register bridge.
package hps_ext_pkg;

    // Command offsets relative to CMD_BASE
    localparam int unsigned CMD_GET_STATUS = 0;
    localparam int unsigned CMD_GET_REGS   = 1;
    localparam int unsigned CMD_SET_REGS   = 2;
    localparam int unsigned CMD_GET_EVENTS = 3;
    localparam int unsigned CMD_ACK_EVENTS = 4;

    // EXT_BUS bit positions
    localparam int unsigned EXT_DOUT_LSB  = 0;
    localparam int unsigned EXT_DIN_LSB   = 16;
    localparam int unsigned EXT_DOUT_EN   = 32;
    localparam int unsigned EXT_IO_STROBE = 33;
    localparam int unsigned EXT_IO_ENABLE = 34;
    localparam int unsigned EXT_W         = 36;

    // Datapath widths
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned BYTE_CNT_W = 5;

endpackage

// File: rtl/hps_ext_if.sv
// EXT_BUS fields between hps_io (master) and the register bridge (slave).
interface hps_ext_if;
    import hps_ext_pkg::*;

    logic [WORD_W-1:0] io_din;
    logic [WORD_W-1:0] io_dout;
    logic              io_strobe;
    logic              io_enable;
    logic              dout_en;

    modport master (output io_din, io_strobe, io_enable, input io_dout, dout_en);
    modport slave  (input io_din, io_strobe, io_enable, output io_dout, dout_en);

endinterface

// File: rtl/hps_ext_evt.sv
// One event channel: toggle detector, wrapping 8-bit counter, optional sticky
// pending bit. Optional feature macro: HPS_EXT_PENDING_EN.
module hps_ext_evt
    import hps_ext_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             evt,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    logic old_evt;
    logic evt_edge_c;

    assign evt_edge_c = evt ^ old_evt;

    // Edge detect and count; a read in the same cycle sees the old value
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_evt <= 1'b0;
            cnt     <= '0;
        end else begin
            old_evt <= evt;
            if (evt_edge_c) cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef HPS_EXT_PENDING_EN
    // Sticky pending bit; a new edge outranks a simultaneous clear
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)           pending <= 1'b0;
        else if (evt_edge_c) pending <= 1'b1;
        else if (clr)        pending <= 1'b0;
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign pending    = 1'b0;
`endif

endmodule

// File: rtl/hps_ext_regs.sv
// Generic HPS extension-bus register bridge: status snapshot reads, control
// register writes with strobes, event toggle counters.
// Optional feature macro: HPS_EXT_PENDING_EN (pending bits, irq, ACK_EVENTS).
module hps_ext_regs
    import hps_ext_pkg::*;
#(
    parameter int unsigned CMD_BASE = 'hF0,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned EVT_CH   = 2,
    parameter int unsigned WR_RESET = 0
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    hps_ext_if.slave                 ext,
    input  logic [WORD_W*NUM_RD-1:0] rd_data,
    input  logic [EVT_CH-1:0]        evt,
    output logic [WORD_W*NUM_WR-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_stb,
    output logic                     irq
);

`ifdef HPS_EXT_PENDING_EN
    localparam int unsigned CMD_MAX_OFS = CMD_ACK_EVENTS;
`else
    localparam int unsigned CMD_MAX_OFS = CMD_GET_EVENTS;
`endif

    localparam logic [WORD_W-1:0] CMD_LO       = WORD_W'(CMD_BASE);
    localparam logic [WORD_W-1:0] CMD_HI       = WORD_W'(CMD_BASE + CMD_MAX_OFS);
    localparam logic [WORD_W-1:0] C_STATUS     = WORD_W'(CMD_BASE + CMD_GET_STATUS);
    localparam logic [WORD_W-1:0] C_GET_REGS   = WORD_W'(CMD_BASE + CMD_GET_REGS);
    localparam logic [WORD_W-1:0] C_SET_REGS   = WORD_W'(CMD_BASE + CMD_SET_REGS);
    localparam logic [WORD_W-1:0] C_GET_EVENTS = WORD_W'(CMD_BASE + CMD_GET_EVENTS);
`ifdef HPS_EXT_PENDING_EN
    localparam logic [WORD_W-1:0] C_ACK_EVENTS = WORD_W'(CMD_BASE + CMD_ACK_EVENTS);
`endif

    logic [WORD_W-1:0]     io_dout;
    logic                  dout_en;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [WORD_W-1:0]     cmd;
    logic [WORD_W-1:0]     snap [NUM_RD];
    logic [CNT_W-1:0]      evt_cnt [EVT_CH];
    logic [EVT_CH-1:0]     pending;
    logic [EVT_CH-1:0]     ack_clr_c;
    logic                  in_range_c;
    logic [WORD_W-1:0]     cnt0_reply_c;

    assign ext.io_dout = io_dout;
    assign ext.dout_en = dout_en;

    assign in_range_c = (ext.io_din >= CMD_LO) && (ext.io_din <= CMD_HI);

`ifdef HPS_EXT_PENDING_EN
    // ACK_EVENTS answers its command word with the pending mask instead of cnt0
    assign cnt0_reply_c = (ext.io_din == C_ACK_EVENTS) ? {8'h00, 8'(pending)}
                                                       : {8'h00, evt_cnt[0]};

    // Pending clear mask from the first data word of ACK_EVENTS
    always_comb begin
        ack_clr_c = '0;
        if (ext.io_enable && ext.io_strobe && byte_cnt == BYTE_CNT_W'(1) &&
            cmd == C_ACK_EVENTS)
            ack_clr_c = ext.io_din[EVT_CH-1:0];
    end
`else
    assign cnt0_reply_c = {8'h00, evt_cnt[0]};
    assign ack_clr_c    = '0;
`endif

    // Event channels
    for (genvar g = 0; g < EVT_CH; g++) begin : g_evt
        hps_ext_evt u_evt (
            .clk_sys (clk_sys),
            .reset   (reset),
            .evt     (evt[g]),
            .clr     (ack_clr_c[g]),
            .cnt     (evt_cnt[g]),
            .pending (pending[g])
        );
    end

    // Command decode, data phase and register writes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            io_dout  <= '0;
            dout_en  <= 1'b0;
            byte_cnt <= '0;
            cmd      <= '0;
            wr_stb   <= '0;
            wr_data  <= {NUM_WR{WORD_W'(WR_RESET)}};
            for (int i = 0; i < NUM_RD; i++) snap[i] <= '0;
        end else begin
            wr_stb <= '0;
            if (!ext.io_enable) begin
                io_dout  <= '0;
                dout_en  <= 1'b0;
                byte_cnt <= '0;
                cmd      <= '0;
            end else if (ext.io_strobe) begin
                io_dout <= '0;
                if (byte_cnt != '1) byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                if (byte_cnt == '0) begin
                    cmd     <= ext.io_din;
                    dout_en <= in_range_c;
                    if (in_range_c) io_dout <= cnt0_reply_c;
                    for (int i = 0; i < NUM_RD; i++) snap[i] <= rd_data[WORD_W*i +: WORD_W];
                end else begin
                    if (cmd == C_STATUS) begin
                        if (byte_cnt == BYTE_CNT_W'(1))
                            io_dout <= {8'(NUM_RD), 8'(NUM_WR)};
                        else if (byte_cnt == BYTE_CNT_W'(2))
                            io_dout <= {8'h00, 8'(EVT_CH)};
                    end
                    if (cmd == C_GET_REGS) begin
                        for (int i = 0; i < NUM_RD; i++)
                            if (int'(byte_cnt) == i + 1) io_dout <= snap[i];
                    end
                    if (cmd == C_SET_REGS) begin
                        for (int i = 0; i < NUM_WR; i++) begin
                            if (int'(byte_cnt) == i + 1) begin
                                wr_data[WORD_W*i +: WORD_W] <= ext.io_din;
                                wr_stb[i]                   <= 1'b1;
                            end
                        end
                    end
                    if (cmd == C_GET_EVENTS) begin
                        for (int i = 0; i < EVT_CH; i++)
                            if (int'(byte_cnt) == i + 1) io_dout <= {8'h00, evt_cnt[i]};
                    end
                end
            end
        end
    end

    // Interrupt: any pending channel
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |pending;
    end

endmodule

// File: tb/tb_hps_ext_regs.sv
// Self-checking bench for hps_ext_regs with a counting/array reference model.
module tb_hps_ext_regs;

    localparam int unsigned NRD = 4;
    localparam int unsigned NWR = 2;
    localparam int unsigned NEV = 2;
    localparam logic [15:0] BASE = 16'h00F0;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [63:0]   rd_data;
    logic [1:0]    evt;
    logic [31:0]   wr_data;
    logic [1:0]    wr_stb;
    logic          irq;

    hps_ext_if bus ();

    hps_ext_regs #(
        .CMD_BASE (32'hF0),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .EVT_CH   (NEV),
        .WR_RESET (0)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ext     (bus),
        .rd_data (rd_data),
        .evt     (evt),
        .wr_data (wr_data),
        .wr_stb  (wr_stb),
        .irq     (irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: event totals, pending flags, written register values
    int          model_cnt [NEV];
    logic [1:0]  model_pend;
    logic [15:0] model_wr [NWR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic xfer(input logic [15:0] w, output logic [15:0] r);
        bus.io_din    = w;
        bus.io_strobe = 1'b1;
        tick();
        bus.io_strobe = 1'b0;
        r = bus.io_dout;
    endtask

    task automatic begin_tx();
        bus.io_enable = 1'b1;
        tick();
    endtask

    task automatic end_tx();
        bus.io_enable = 1'b0;
        tick();
    endtask

    task automatic toggles(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            evt[ch] = ~evt[ch];
            tick();
            model_cnt[ch]++;
            model_pend[ch] = 1'b1;
        end
    endtask

    function automatic logic [15:0] cnt_word(input int ch);
        return {8'h00, 8'(model_cnt[ch] % 256)};
    endfunction

    function automatic logic [31:0] wr_word();
        return {model_wr[1], model_wr[0]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic [63:0] snap;
        logic [15:0] v0, v1;

        bus.io_din = '0; bus.io_strobe = 1'b0; bus.io_enable = 1'b0;
        evt = '0; rd_data = '0;
        for (int i = 0; i < NEV; i++) model_cnt[i] = 0;
        for (int i = 0; i < NWR; i++) model_wr[i] = '0;
        model_pend = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_io_dout", bus.io_dout, 0);
        chk("rst_dout_en", bus.dout_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b0;
        tick();

        // GET_STATUS
        begin_tx();
        xfer(BASE + 16'd0, r); chk("status_cmd", r, cnt_word(0));
        chk("status_dout_en", bus.dout_en, 1);
        xfer(16'h0, r); chk("status_b1", r, {8'(NRD), 8'(NWR)});
        xfer(16'h0, r); chk("status_b2", r, {8'h00, 8'(NEV)});
        xfer(16'h0, r); chk("status_b3", r, 0);
        end_tx();
        chk("idle_dout_en", bus.dout_en, 0);
        chk("idle_io_dout", bus.io_dout, 0);

        // GET_REGS: replies frozen at the command strobe
        for (int rep = 0; rep < 3; rep++) begin
            rd_data = {$urandom, $urandom};
            snap    = rd_data;
            begin_tx();
            xfer(BASE + 16'd1, r);
            for (int i = 0; i < 4; i++) begin
                rd_data[16*i +: 16] = 16'($urandom);
                rd_data[16 +: 16]   = ~rd_data[16 +: 16];
                xfer(16'h0, r);
                chk($sformatf("regs_w%0d", i), r, snap[16*i +: 16]);
            end
            xfer(16'h0, r); chk("regs_beyond", r, 0);
            chk("regs_dout_en", bus.dout_en, 1);
            end_tx();
        end

        // SET_REGS: directed, then random values
        for (int rep = 0; rep < 4; rep++) begin
            v0 = (rep == 0) ? 16'h1234 : 16'($urandom);
            v1 = (rep == 0) ? 16'hABCD : 16'($urandom);
            begin_tx();
            xfer(BASE + 16'd2, r); chk("set_cmd", r, cnt_word(0));
            chk("set_stb_idle", wr_stb, 0);
            xfer(v0, r); model_wr[0] = v0;
            chk("set_stb0", wr_stb, 2'b01);
            chk("set_data0", wr_data, wr_word());
            xfer(v1, r); model_wr[1] = v1;
            chk("set_stb1", wr_stb, 2'b10);
            chk("set_data1", wr_data, wr_word());
            xfer(16'($urandom), r);
            chk("set_extra_stb", wr_stb, 0);
            chk("set_extra_data", wr_data, wr_word());
            tick();
            chk("set_stb_after", wr_stb, 0);
            end_tx();
        end

        // Event counter wrap on channel 1
        toggles(1, 257);
        tick();
        begin_tx();
        xfer(BASE + 16'd3, r); chk("evt_cmd", r, cnt_word(0));
        xfer(16'h0, r); chk("evt_b1", r, cnt_word(0));
        xfer(16'h0, r); chk("evt_b2_wrap", r, 16'h0001);
        xfer(16'h0, r); chk("evt_b3", r, 0);
        end_tx();

        // Edge coinciding with the read strobe returns the old count
        begin_tx();
        xfer(BASE + 16'd3, r);
        xfer(16'h0, r);
        v0 = cnt_word(1);
        evt[1] = ~evt[1];
        xfer(16'h0, r); chk("evt_edge_on_read", r, v0);
        model_cnt[1]++; model_pend[1] = 1'b1;
        end_tx();
        begin_tx();
        xfer(BASE + 16'd3, r);
        xfer(16'h0, r);
        xfer(16'h0, r); chk("evt_after_edge", r, cnt_word(1));
        end_tx();

        // Random event bursts
        for (int rep = 0; rep < 4; rep++) begin
            toggles(0, int'($urandom_range(0, 300)));
            toggles(1, int'($urandom_range(0, 40)));
            begin_tx();
            xfer(BASE + 16'd3, r); chk("rnd_evt_cmd", r, cnt_word(0));
            xfer(16'h0, r); chk("rnd_evt_b1", r, cnt_word(0));
            xfer(16'h0, r); chk("rnd_evt_b2", r, cnt_word(1));
            end_tx();
        end

        // Out-of-range command: silent, no writes
        begin_tx();
        xfer(16'h00F5, r);
        chk("oor_dout_en", bus.dout_en, 0);
        chk("oor_cmd_dout", r, 0);
        for (int i = 0; i < 3; i++) begin
            xfer(16'($urandom), r);
            chk("oor_dout", r, 0);
            chk("oor_stb", wr_stb, 0);
        end
        chk("oor_data", wr_data, wr_word());
        end_tx();

`ifdef HPS_EXT_PENDING_EN
        // Clear everything, then exercise set / clear / set-wins
        begin_tx();
        xfer(BASE + 16'd4, r); chk("ack_cmd_pend", r, {8'h00, 6'h00, model_pend});
        xfer(16'h00FF, r); model_pend = '0;
        end_tx();
        tick();
        chk("irq_cleared", irq, 0);
        toggles(0, 1);
        toggles(1, 1);
        tick();
        chk("irq_set", irq, 1);
        begin_tx();
        xfer(BASE + 16'd4, r); chk("ack_pend3", r, 16'h0003);
        xfer(16'h0001, r); model_pend[0] = 1'b0;
        end_tx();
        tick();
        chk("irq_pend2", irq, 1);
        begin_tx();
        xfer(BASE + 16'd4, r); chk("ack_pend2", r, 16'h0002);
        xfer(16'h0002, r); model_pend[1] = 1'b0;
        end_tx();
        tick();
        chk("irq_zero", irq, 0);
        begin_tx();
        xfer(BASE + 16'd4, r);
        evt[0] = ~evt[0];
        xfer(16'h0001, r);
        model_cnt[0]++; model_pend[0] = 1'b1;
        end_tx();
        tick();
        chk("irq_set_wins", irq, 1);
        begin_tx();
        xfer(BASE + 16'd4, r); chk("ack_set_wins", r, 16'h0001);
        end_tx();
`else
        // Without pending logic the next code is out of range and irq stays low
        begin_tx();
        xfer(BASE + 16'd4, r);
        chk("f4_dout_en", bus.dout_en, 0);
        chk("f4_dout", r, 0);
        xfer(16'hFFFF, r);
        chk("f4_data", r, 0);
        end_tx();
        chk("irq_tied", irq, 0);
`endif

        // Reset mid-SET_REGS
        for (int ch = 0; ch < NEV; ch++) if (evt[ch]) toggles(ch, 1);
        begin_tx();
        xfer(BASE + 16'd2, r);
        xfer(16'h5A5A, r);
        chk("pre_rst_data", wr_data[15:0], 16'h5A5A);
        #2 reset = 1'b1;
        #1;
        chk("arst_wr_data", wr_data, 0);
        chk("arst_wr_stb", wr_stb, 0);
        chk("arst_dout_en", bus.dout_en, 0);
        chk("arst_irq", irq, 0);
        for (int i = 0; i < NWR; i++) model_wr[i] = '0;
        for (int i = 0; i < NEV; i++) model_cnt[i] = 0;
        model_pend = '0;
        bus.io_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        begin_tx();
        xfer(BASE + 16'd0, r); chk("post_rst_cmd", r, 0);
        chk("post_rst_dout_en", bus.dout_en, 1);
        xfer(16'h0, r); chk("post_rst_b1", r, {8'(NRD), 8'(NWR)});
        end_tx();
        begin_tx();
        xfer(BASE + 16'd3, r);
        xfer(16'h0, r); chk("post_rst_evt0", r, 0);
        xfer(16'h0, r); chk("post_rst_evt1", r, 0);
        end_tx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hps_ext_regs.md
Name: hps_ext_regs

Overview:
- Parametrised HPS extension-bus bridge on the 36-bit EXT_BUS. Generalises the fixed status/init command decoder into a generic register bridge.
- Adds N read-only status words, captured as a coherent snapshot per transaction.
- Adds M writable control registers with write strobes, and K event channels with toggle counters.
- Sits between hps_io's EXT_BUS and core logic, in the clk_sys domain.

Parameters:
- CMD_BASE, 'hF0, first command code; commands are CMD_BASE+0..+3 (+4 with the optional feature).
- NUM_RD, 4, number of 16-bit status words readable (1..30).
- NUM_WR, 2, number of 16-bit control registers writable (1..30).
- EVT_CH, 2, number of event toggle channels (1..8).
- WR_RESET, 0, reset value of every control register (16-bit).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- EXT_BUS  inout  36  [15:0] dout to HPS, [31:16] din from HPS, [32] dout_en, [33] io_strobe, [34] io_enable
- rd_data  in  16*NUM_RD  status words; word i at [16i+15:16i]
- evt  in  EVT_CH  event toggle inputs (clk_sys domain); each edge is one event
- wr_data  out  16*NUM_WR  control registers
- wr_stb  out  NUM_WR  one-cycle pulse per register write
- irq  out  1  OR of pending event bits (optional feature; else 0)

Behaviour:
- Reset (async, dominates everything): io_dout=0, dout_en=0, byte_cnt=0, cmd=0, event counters=0, wr_data=WR_RESET, wr_stb=0, irq=0, snapshot=0.
- io_enable=0: io_dout=0, dout_en=0, byte_cnt=0, cmd=0 on the next edge. Abort mid-transaction: already-written registers keep their values; no further strobes.
- Each io_strobe with io_enable=1 advances byte_cnt (5-bit, saturates at 31). io_dout is registered and valid the cycle after the strobe. io_dout defaults to 0 on any strobe not assigned below.
- byte_cnt==0 (command word):
  - cmd<=io_din.
  - dout_en<=1 iff CMD_BASE <= io_din <= CMD_MAX.
  - For any in-range command, io_dout<={8'h00, evt_cnt[0]}.
  - Snapshot register file <= rd_data, in the same cycle.
- CMD_BASE+0 GET_STATUS: byte 1 -> {NUM_RD[7:0], NUM_WR[7:0]}; byte 2 -> {8'h00, EVT_CH[7:0]}.
- CMD_BASE+1 GET_REGS: byte i (1..NUM_RD) -> snapshot word i-1; bytes beyond -> 0. Live rd_data changes during the transaction are invisible.
- CMD_BASE+2 SET_REGS: byte i (1..NUM_WR) -> wr_data[i-1]<=io_din, with wr_stb[i-1]=1 for exactly the following cycle; bytes beyond are ignored.
- CMD_BASE+3 GET_EVENTS: byte i (1..EVT_CH) -> {8'h00, evt_cnt[i-1]}.
- Event channels:
  - old_evt is registered; (evt ^ old_evt) increments an 8-bit counter that wraps 255->0.
  - Counting is independent of bus activity.
  - An edge coinciding with a counter read: the read returns the pre-increment value.
- wr_stb is 0 outside a SET_REGS data strobe. Consecutive strobes on successive cycles give back-to-back pulses.
- Out-of-range command: dout_en=0, io_dout=0, no side effects for the whole transaction.

Optional Feature:
- Macro: HPS_EXT_PENDING_EN.
- With the macro:
  - Per-channel sticky pending bit, set on each event edge.
  - irq = |pending.
  - CMD_MAX = CMD_BASE+4. ACK_EVENTS (CMD_BASE+4): byte 1 clears pending bits where io_din[j]=1; the cnt0 reply for this command is {8'h00, pending}.
  - Set and clear in the same cycle: set wins.
- Without the macro: no pending logic, irq tied 0, CMD_MAX = CMD_BASE+3, and CMD_BASE+4 is out of range.

Decomposition:
- Package hps_ext_pkg:
  - Command offsets (GET_STATUS=0, GET_REGS=1, SET_REGS=2, GET_EVENTS=3, ACK_EVENTS=4).
  - EXT_BUS bit-position constants.
  - Counter width constant (8).
- Sub-module hps_ext_evt: one channel's toggle detector, 8-bit counter and optional pending bit. Instantiated EVT_CH times via generate.

Test Plan:
- Reset asserted mid-SET_REGS (after byte 1 of 2) -> wr_data = WR_RESET, wr_stb=0, dout_en=0 asynchronously; the next transaction decodes normally.
- CMD_BASE=F0, NUM_RD=4; send F1, change rd_data[1] between strobes, read 4 words -> the words equal rd_data at the command strobe; a 5th read -> 0000; dout_en=1.
- SET_REGS: send F2, 1234, ABCD -> wr_data0=1234 with one wr_stb[0] pulse, then wr_data1=ABCD with one wr_stb[1] pulse; a 3rd data word is ignored.
- Toggle evt[1] 257 times, then GET_EVENTS F3 -> byte 1 = 0000, byte 2 = 0001 (wrap). An edge on the read strobe cycle -> the old value is returned.
- Command 00F5 (out of range) -> dout_en=0, io_dout=0 for all bytes, no wr_stb.
- HPS_EXT_PENDING_EN: events on ch0 and ch1 -> irq=1; F4 then 0001 -> pending=2, irq=1; F4 then 0002 -> irq=0. Event coinciding with the clear -> the bit stays set.
